// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle multiply/divide unit holding the HI/LO
//                architectural registers of a MIPS-style pipeline.
//                MUL/MULU take 5 busy cycles and DIV/DIVU take 10. The result
//                is computed from the operands sampled on the accepting edge,
//                held in pending registers, and written to HI/LO on the edge
//                where busy falls. mthi/mtlo write HI/LO directly in one cycle.
//
//  Ports       : clk      - clock, rising-edge active
//                reset    - synchronous active-high reset
//                start    - E-stage instruction is mult/multu/div/divu
//                move_to  - E-stage instruction is mthi/mtlo
//                sel[2:0] - 0 MUL, 1 MULU, 2 DIV, 3 DIVU, 4 HI, 5 LO, 6/7 none
//                a[31:0]  - forwarded rs value
//                b[31:0]  - forwarded rt value
//                flush    - exception/interrupt taken; E-stage op must not commit
//                busy     - registered; high while an operation is in flight
//                out      - HI when sel=4, LO otherwise
//
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        move_to,
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] out
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MUL_RUN = 2'd1;
    localparam logic [1:0] c_ST_DIV_RUN = 2'd2;

    localparam logic [3:0] c_MUL_CYCLES = 4'd5;
    localparam logic [3:0] c_DIV_CYCLES = 4'd10;

    localparam logic [2:0] c_SEL_MUL  = 3'd0;
    localparam logic [2:0] c_SEL_DIV  = 3'd2;
    localparam logic [2:0] c_SEL_HI   = 3'd4;
    localparam logic [2:0] c_SEL_LO   = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;
    logic        r_busy;

    logic [1:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;
    logic        w_pend_wr_nxt;

    // ------------------------------------------------------------------
    // Arithmetic on the operands present in the accepting cycle
    // ------------------------------------------------------------------
    logic        w_mul_signed;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    // sel=0 is the only signed multiply; sign-extending both operands to
    // 64 bits lets one unsigned multiplier produce both products mod 2^64.
    assign w_mul_signed = (sel == c_SEL_MUL);
    assign w_mul_a      = {{32{w_mul_signed & a[31]}}, a};
    assign w_mul_b      = {{32{w_mul_signed & b[31]}}, b};
    assign w_prod       = w_mul_a * w_mul_b;

    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Signed division works on magnitudes so 0x80000000 / -1 needs no
    // special case: |a|=0x80000000, |b|=1, quotient wraps to 0x80000000.
    assign w_div_signed = (sel == c_SEL_DIV);
    assign w_a_neg      = w_div_signed & a[31];
    assign w_b_neg      = w_div_signed & b[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag      = w_b_neg ? (32'd0 - b) : b;
    // A zero divisor is replaced so the divider never sees x/0; that result
    // is never committed.
    assign w_divisor    = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_divisor;
    assign w_r_mag      = w_a_mag % w_divisor;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic w_idle;
    logic w_accept;
    logic w_move;

    assign w_idle   = (r_state == c_ST_IDLE);
    // sel[2]==0 covers codes 0..3, the four arithmetic operations.
    assign w_accept = start && !flush && w_idle && !sel[2];
    assign w_move   = move_to && !flush && w_idle &&
                      ((sel == c_SEL_HI) || (sel == c_SEL_LO));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;

        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (sel[1]) begin
                        w_state_nxt   = c_ST_DIV_RUN;
                        w_cnt_nxt     = c_DIV_CYCLES;
                        w_pend_hi_nxt = w_rem;
                        w_pend_lo_nxt = w_quot;
                        w_pend_wr_nxt = (b != 32'd0);
                    end else begin
                        w_state_nxt   = c_ST_MUL_RUN;
                        w_cnt_nxt     = c_MUL_CYCLES;
                        w_pend_hi_nxt = w_prod[63:32];
                        w_pend_lo_nxt = w_prod[31:0];
                        w_pend_wr_nxt = 1'b1;
                    end
                end else if (w_move) begin
                    if (sel == c_SEL_HI) begin
                        w_hi_nxt = a;
                    end else begin
                        w_lo_nxt = a;
                    end
                end
            end

            c_ST_MUL_RUN, c_ST_DIV_RUN: begin
                // flush is ignored here: the running instruction is already
                // past M and must commit.
                if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_busy    <= (w_state_nxt != c_ST_IDLE);
        end
    end

    assign busy = r_busy;
    assign out  = (sel == c_SEL_HI) ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit. Directed vector table,
//                hand-written corner sequences (flush, reset mid-operation,
//                dropped moves) and randomized operations compared against a
//                plain-arithmetic HI/LO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        move_to;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] out;

    int checks;
    int failures;

    muldiv_unit u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .move_to (move_to),
        .sel     (sel),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing start while the unit is busy is a protocol violation.
    always @(posedge clk) begin
        assert (reset || !(start && busy))
            else $error("protocol violation: start issued while busy");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        logic [2:0] s;
        s   = sel;
        sel = 3'd4;
        #1;
        hi  = out;
        sel = 3'd5;
        #1;
        lo  = out;
        sel = s;
        #1;
    endtask

    task automatic do_move(input logic [2:0] s, input logic [31:0] v, input logic f);
        move_to = 1'b1;
        sel     = s;
        a       = v;
        flush   = f;
        step();
        move_to = 1'b0;
        flush   = 1'b0;
        sel     = 3'd7;
    endtask

    // Issue one operation, scramble operands afterwards, count busy cycles
    // and capture HI/LO in the first busy cycle.
    task automatic do_op(input logic [2:0] s, input logic [31:0] aa, input logic [31:0] bb,
                         output int lat, output logic [31:0] hi_mid, output logic [31:0] lo_mid);
        chk("busy_idle_before_start", {31'd0, busy}, 32'd0);
        start = 1'b1;
        sel   = s;
        a     = aa;
        b     = bb;
        step();
        start  = 1'b0;
        sel    = 3'd7;
        a      = $urandom();
        b      = $urandom();
        lat    = 0;
        hi_mid = 32'd0;
        lo_mid = 32'd0;
        while (busy && lat < 20) begin
            lat++;
            if (lat == 1) read_hilo(hi_mid, lo_mid);
            step();
        end
    endtask

    // HI/LO reference computed with wide integer arithmetic.
    function automatic void model(input logic [2:0] s, input logic [31:0] aa, input logic [31:0] bb,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        case (s)
            3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'd0, aa} * {32'd0, bb}; hi = p[63:32]; lo = p[31:0]; end
            3'd2: if (bb != 0) begin
                q = sa / sb; r = sa % sb;
                lo = q[31:0]; hi = r[31:0];
            end
            3'd3: if (bb != 0) begin
                q = longint'(aa) / longint'(bb); r = longint'(aa) % longint'(bb);
                lo = q[31:0]; hi = r[31:0];
            end
            default: ;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] hi_mid;
        logic [31:0] lo_mid;
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;

        checks   = 0;
        failures = 0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,          32'h0,  32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0,  32'h0,  32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'h0,  32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{3'd3, 32'd7,         32'd0,          32'h11, 32'h22, 32'h0000_0011, 32'h0000_0022, 10};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h5,  32'h6,  32'h0000_0000, 32'h8000_0000, 10};
        vecs[5] = '{3'd3, 32'hFFFF_FFFF, 32'h10,         32'h0,  32'h0,  32'h0000_000F, 32'h0FFF_FFFF, 10};
        vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'h0,  32'h0,  32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[7] = '{3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB,  32'h7,  32'h8,  32'h0000_0000, 32'h0000_000F, 5};

        reset   = 1'b1;
        start   = 1'b0;
        move_to = 1'b0;
        sel     = 3'd7;
        a       = 32'd0;
        b       = 32'd0;
        flush   = 1'b0;
        step();
        step();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;
        step();

        // Directed vectors
        foreach (vecs[i]) begin
            do_move(3'd4, vecs[i].pre_hi, 1'b0);
            do_move(3'd5, vecs[i].pre_lo, 1'b0);
            do_op(vecs[i].op, vecs[i].va, vecs[i].vb, lat, hi_mid, lo_mid);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_hi_not_early", i), hi_mid, vecs[i].pre_hi);
            chk($sformatf("vec%0d_lo_not_early", i), lo_mid, vecs[i].pre_lo);
            read_hilo(hi, lo);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // move_to under flush is suppressed, then takes effect without flush
        do_move(3'd4, 32'h1234_5678, 1'b0);
        do_move(3'd4, 32'hDEAD_BEEF, 1'b1);
        read_hilo(hi, lo);
        chk("mthi_flushed_hi", hi, 32'h1234_5678);
        do_move(3'd4, 32'hDEAD_BEEF, 1'b0);
        sel = 3'd4;
        #1;
        chk("mthi_out", out, 32'hDEAD_BEEF);
        chk("mthi_no_busy", {31'd0, busy}, 32'd0);
        sel = 3'd7;

        // move_to with sel=6 is dropped
        do_move(3'd5, 32'hCAFE_0001, 1'b0);
        do_move(3'd6, 32'h5555_AAAA, 1'b0);
        read_hilo(hi, lo);
        chk("mt_sel6_hi", hi, 32'hDEAD_BEEF);
        chk("mt_sel6_lo", lo, 32'hCAFE_0001);

        // start together with flush is suppressed
        start = 1'b1; flush = 1'b1; sel = 3'd1; a = 32'd9; b = 32'd9;
        step();
        start = 1'b0; flush = 1'b0; sel = 3'd7;
        chk("flushed_start_busy", {31'd0, busy}, 32'd0);
        repeat (6) step();
        read_hilo(hi, lo);
        chk("flushed_start_lo", lo, 32'hCAFE_0001);

        // flush during a running operation does not abort it
        start = 1'b1; sel = 3'd0; a = 32'd6; b = 32'd7;
        step();
        start = 1'b0; sel = 3'd7;
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        lat = 0;
        while (busy && lat < 20) begin lat++; step(); end
        read_hilo(hi, lo);
        chk("flush_run_hi", hi, 32'd0);
        chk("flush_run_lo", lo, 32'd42);

        // Reset in busy cycle 3 of MULU 3*4 discards the result
        do_move(3'd4, 32'hAAAA_0000, 1'b0);
        start = 1'b1; sel = 3'd1; a = 32'd3; b = 32'd4;
        step();
        start = 1'b0; sel = 3'd7;
        step();
        step();
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (8) step();
        read_hilo(hi, lo);
        chk("rst_mid_no_commit_hi", hi, 32'd0);
        chk("rst_mid_no_commit_lo", lo, 32'd0);
        chk("rst_mid_still_idle", {31'd0, busy}, 32'd0);

        // Randomized operations against the reference model
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = $urandom();
                if ($urandom_range(0, 1) == 1) begin
                    do_move(3'd4, ra, 1'b0); m_hi = ra;
                end else begin
                    do_move(3'd5, ra, 1'b0); m_lo = ra;
                end
            end
            op = 3'($urandom_range(0, 3));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(op, ra, rb, lat, hi_mid, lo_mid);
            chk($sformatf("rnd%0d_latency", n), 32'(lat), (op < 3'd2) ? 32'd5 : 32'd10);
            model(op, ra, rb, m_hi, m_lo);
            read_hilo(hi, lo);
            chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", n, op, ra, rb), hi, m_hi);
            chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", n, op, ra, rb), lo, m_lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL expose a `clk` input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose a `reset` input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL expose a `start` input, 1 bit: the E-stage instruction is mult/multu/div/divu.
REQ-004 The block SHALL expose a `move_to` input, 1 bit: the E-stage instruction is mthi/mtlo.
REQ-005 The block SHALL expose a `sel` input, 3 bits: operation/select code; 0=MUL, 1=MULU, 2=DIV, 3=DIVU, 4=SELECT_HI, 5=SELECT_LO, 7=none.
REQ-006 The block SHALL expose an `a` input, 32 bits: forwarded rs value.
REQ-007 The block SHALL expose a `b` input, 32 bits: forwarded rt value.
REQ-008 The block SHALL expose a `flush` input, 1 bit: an exception or interrupt is being taken this cycle; the E-stage MDU instruction must not commit.
REQ-009 The block SHALL expose a `busy` output, 1 bit: an operation is in flight.
REQ-010 The block SHALL expose an `out` output, 32 bits: HI when sel=4, LO otherwise; feeds mfhi/mflo.

Function
REQ-011 The unit SHALL hold two 32-bit architectural registers, HI and LO, plus a down-counter and pending-result registers.
REQ-012 The unit SHALL have three states: IDLE, MUL_RUN and DIV_RUN.
- IDLE -> MUL_RUN when start && !flush && sel in {0,1}.
- IDLE -> DIV_RUN when start && !flush && sel in {2,3}.
- MUL_RUN or DIV_RUN -> IDLE when the counter reaches 1.
REQ-013 On an accepted start, the unit SHALL compute the result from a and b sampled in that cycle and store it in the pending registers; later changes on a and b SHALL NOT affect the result.
REQ-014 MUL SHALL be a 64-bit signed product and MULU a 64-bit unsigned product; HI receives bits [63:32] and LO receives bits [31:0].
REQ-015 DIV SHALL give the signed quotient in LO and the signed remainder in HI, truncating toward zero with the remainder taking the sign of the dividend; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-016 DIVU SHALL give the unsigned quotient in LO and the unsigned remainder in HI.
REQ-017 If b=0 on DIV or DIVU, the unit SHALL still run the full latency, and HI and LO SHALL be left unchanged at completion.
REQ-018 Latency: busy SHALL rise the cycle after an accepted start; it SHALL stay high 5 cycles for MUL/MULU and 10 cycles for DIV/DIVU.
REQ-019 HI and LO SHALL be written at the clock edge on which busy falls; out reflects the new value the following cycle.
REQ-020 busy SHALL be registered, so it is low in the start cycle itself; the hazard unit stalls any MDU instruction when (start || busy).
REQ-021 A start received while busy SHALL be ignored; that combination is a protocol violation and the bench SHALL flag it with an assertion.
REQ-022 move_to && !flush && !busy SHALL write a to HI when sel=4 and to LO when sel=5, at that edge; it takes one cycle and does not assert busy.
REQ-023 When flush=1, start and move_to SHALL be suppressed in the same cycle, with no state change.
REQ-024 flush SHALL NOT abort an operation already running; it completes and commits, because its instruction has already passed M.
REQ-025 out SHALL be combinational from HI/LO and sel; it SHALL NOT expose pending results before completion.
REQ-026 sel values 6 and 7 SHALL cause no action; when move_to is high with such a value, the write SHALL be dropped.

Reset
REQ-027 When reset=1 at a clock edge, the unit SHALL clear HI, LO, the pending registers and the counter to 0, go to IDLE, and drive busy=0.
REQ-028 Reset SHALL take priority over start, move_to and flush.
REQ-029 Reset during MUL_RUN or DIV_RUN SHALL discard the pending result.

Verification
REQ-030 The bench SHALL apply MUL with a=0xFFFFFFFF, b=2 and check: busy high cycles 1-5; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 The bench SHALL apply MULU with a=0xFFFFFFFF, b=2 and check HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-032 The bench SHALL apply DIV with a=-7 (0xFFFFFFF9), b=2 and check: after 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-033 The bench SHALL apply DIVU with a=7, b=0, starting from HI=0x11, LO=0x22, and check: busy for 10 cycles; HI=0x11 and LO=0x22 remain.
REQ-034 The bench SHALL apply move_to with sel=4, a=0xDEADBEEF together with flush=1 and check HI unchanged; it SHALL then repeat with flush=0 and check out=0xDEADBEEF next cycle with sel=4.
REQ-035 The bench SHALL start MULU 3*4, assert reset at busy cycle 3, and check: next cycle busy=0, HI=0, LO=0, and no later commit.
